// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and the RV32I subset decoder for the ALU issue unit.
package alu_pkg;

  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SUB = 3'b001;
  localparam logic [2:0] FUNC_AND = 3'b010;
  localparam logic [2:0] FUNC_OR  = 3'b011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;

  typedef struct packed {
    logic       legal;
    logic       use_imm;
    logic [2:0] func;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = '0;
    f3 = instr[14:12];
    f7 = instr[31:25];
    case (instr[6:0])
      OPC_OP: begin
        if (f3 == F3_ADD && f7 == F7_BASE) begin
          d.legal = 1'b1; d.func = FUNC_ADD;
        end else if (f3 == F3_ADD && f7 == F7_SUB) begin
          d.legal = 1'b1; d.func = FUNC_SUB;
        end else if (f3 == F3_AND && f7 == F7_BASE) begin
          d.legal = 1'b1; d.func = FUNC_AND;
        end else if (f3 == F3_OR && f7 == F7_BASE) begin
          d.legal = 1'b1; d.func = FUNC_OR;
        end
      end
      OPC_OP_IMM: begin
        d.use_imm = 1'b1;
        case (f3)
          F3_ADD:  begin d.legal = 1'b1; d.func = FUNC_ADD; end
          F3_AND:  begin d.legal = 1'b1; d.func = FUNC_AND; end
          F3_OR:   begin d.legal = 1'b1; d.func = FUNC_OR;  end
          default: d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/register_file.sv
// Register file: two combinational read ports plus a debug read port, one write port; x0 reads zero.
// Writes land at the clock edge; synchronous clear on rst takes priority over a same-cycle write.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one decoded RV32I ALU op at a time: accept -> EXEC -> WB, three cycles per instruction.
// instr_ready is high only in IDLE; instr_valid seen while busy is ignored, so upstream must hold.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [2:0]      alu_func,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal_instr,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_t          state_q, state_d;
  logic [2:0]      alu_func_q, alu_func_d;
  logic [XLEN-1:0] alu_op1_q, alu_op1_d;
  logic [XLEN-1:0] alu_op2_q, alu_op2_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] rs1_data, rs2_data, imm_ext;
  dec_t            dec;

  assign dec     = decode(instr);
  assign imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (instr[19:15]),
    .rs1_data (rs1_data),
    .rs2_addr (instr[24:20]),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_valid_q),
    .waddr    (wb_rd_q),
    .wdata    (wb_data_q)
  );

  // The ALU result is captured at the end of EXEC so WB can both show and commit it.
  always_comb begin
    state_d    = state_q;
    alu_func_d = alu_func_q;
    alu_op1_d  = alu_op1_q;
    alu_op2_d  = alu_op2_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (dec.legal) begin
            state_d    = ST_EXEC;
            alu_func_d = dec.func;
            alu_op1_d  = rs1_data;
            alu_op2_d  = dec.use_imm ? imm_ext : rs2_data;
            rd_d       = instr[11:7];
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        state_d    = ST_WB;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = alu_result;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_func_q <= FUNC_ADD;
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_func_q <= alu_func_d;
      alu_op1_q  <= alu_op1_d;
      alu_op2_q  <= alu_op2_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign instr_ready   = (state_q == ST_IDLE);
  assign alu_func      = alu_func_q;
  assign alu_op1       = alu_op1_q;
  assign alu_op2       = alu_op2_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign illegal_instr = illegal_q;

endmodule
